btn_mode_sel: RTL and testbench

BTN_MODE_SEL -- requirements
Module: btn_mode_sel

---
 rtl/btn_mode_sel.sv | 117 +++++++++++
 tb/tb_btn_mode_sel.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/btn_mode_sel.sv
// Push-button mode selector: synchronizes and debounces three buttons, then
// latches a one-hot pattern select from the most recent qualifying press.
//
// state | meaning
// ------+---------------------------------------------
// NONE  | no mode selected since reset, sel = 000
// P1    | btn1 pattern selected, sel1 high
// P2    | btn2 pattern selected, sel2 high
// P3    | btn3 pattern selected, sel3 high
module btn_mode_sel #(
   parameter int DB_CYCLES   = 1000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       btn1,
   input  logic       btn2,
   input  logic       btn3,
   output logic       sel1,
   output logic       sel2,
   output logic       sel3,
   output logic [2:0] db,
   output logic       mode_chg
);

   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      NONE = 2'd0,
      P1   = 2'd1,
      P2   = 2'd2,
      P3   = 2'd3
   } mode_t;

   logic [2:0] raw;
   logic [2:0] db_d;
   logic [2:0] press;
   mode_t      state;
   mode_t      tgt;

   assign raw = {btn3, btn2, btn1};

   generate
      for (genvar i = 0; i < 3; i++) begin : g_btn
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   synced;
         logic [CW-1:0]          cnt;
         logic                   db_q;

         assign synced = sync_q[SYNC_STAGES-1];
         assign db[i]  = db_q;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               sync_q <= '0;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
            end
         end

         // Any cycle that agrees with the accepted level restarts the window.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               cnt  <= '0;
               db_q <= 1'b0;
            end else if (synced == db_q) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               db_q <= synced;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         db_d <= 3'b000;
      end else begin
         db_d <= db;
      end
   end

   assign press = db & ~db_d;

   // Lower-priority presses in the same cycle are dropped, not deferred.
   always_comb begin
      tgt = state;
      if (press[0]) begin
         tgt = P1;
      end else if (press[1]) begin
         tgt = P2;
      end else if (press[2]) begin
         tgt = P3;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= NONE;
         sel1     <= 1'b0;
         sel2     <= 1'b0;
         sel3     <= 1'b0;
         mode_chg <= 1'b0;
      end else begin
         state    <= tgt;
         sel1     <= (tgt == P1);
         sel2     <= (tgt == P2);
         sel3     <= (tgt == P3);
         mode_chg <= (tgt != state);
      end
   end

endmodule

// File: tb/tb_btn_mode_sel.sv
// Bench for btn_mode_sel: directed step table, async-reset sequence and random
// button activity compared every cycle against a sample-history reference model.
module tb_btn_mode_sel;

   localparam int DB   = 4;
   localparam int SYNC = 2;
   localparam int H    = SYNC + DB;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       btn1 = 1'b0;
   logic       btn2 = 1'b0;
   logic       btn3 = 1'b0;
   logic       sel1, sel2, sel3;
   logic [2:0] db;
   logic       mode_chg;

   btn_mode_sel #(.DB_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .btn1     (btn1),
      .btn2     (btn2),
      .btn3     (btn3),
      .sel1     (sel1),
      .sel2     (sel2),
      .sel3     (sel3),
      .db       (db),
      .mode_chg (mode_chg)
   );

   initial forever #5 CLK = ~CLK;

   // Reference: a level is accepted once the synchronized samples seen by the
   // debouncer have disagreed with it for DB consecutive edges.
   logic [2:0] hist [H];
   int         m_mode = 0;
   logic [2:0] m_db   = 3'b000;
   logic [2:0] m_pend = 3'b000;
   logic       m_chg  = 1'b0;

   task automatic model_step();
      int         t;
      logic [2:0] nd;
      bit         all_diff;
      if (RST) begin
         for (int k = 0; k < H; k++) hist[k] = 3'b000;
         m_mode = 0;
         m_db   = 3'b000;
         m_pend = 3'b000;
         m_chg  = 1'b0;
      end else begin
         t = m_pend[0] ? 1 : m_pend[1] ? 2 : m_pend[2] ? 3 : 0;
         m_chg = (t != 0) && (t != m_mode);
         if (m_chg) m_mode = t;
         for (int k = H - 1; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = {btn3, btn2, btn1};
         nd = m_db;
         for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int a = SYNC; a < H; a++)
               if (hist[a][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_db[b];
         end
         m_pend = nd & ~m_db;
         m_db   = nd;
      end
   endtask

   initial begin
      for (int k = 0; k < H; k++) hist[k] = 3'b000;
      forever begin
         @(posedge CLK or posedge RST);
         model_step();
      end
   end

   int m_checks = 0;
   int m_errors = 0;

   initial begin
      logic [2:0] exp_sel;
      forever begin
         @(negedge CLK);
         exp_sel = (m_mode == 1) ? 3'b100 : (m_mode == 2) ? 3'b010 :
                   (m_mode == 3) ? 3'b001 : 3'b000;
         m_checks++;
         if ({sel1, sel2, sel3} !== exp_sel || db !== m_db || mode_chg !== m_chg) begin
            m_errors++;
            $display("FAIL model t=%0t got sel=%b db=%b chg=%b want sel=%b db=%b chg=%b",
                     $time, {sel1, sel2, sel3}, db, mode_chg, exp_sel, m_db, m_chg);
         end
      end
   end

   typedef struct {
      logic       rst;
      logic [2:0] btn;
      int         cycles;
      logic [2:0] exp_sel;
      logic [2:0] exp_db;
      logic       exp_chg;
      string      name;
   } step_t;

   step_t steps[35];
   int    checks = 0;
   int    errors = 0;

   task automatic run(input logic r, input logic [2:0] b, input int n);
      RST = r;
      {btn3, btn2, btn1} = b;
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [2:0] es, input logic [2:0] ed,
                      input logic ec);
      checks++;
      if ({sel1, sel2, sel3} !== es || db !== ed || mode_chg !== ec) begin
         errors++;
         $display("FAIL %s got sel=%b db=%b chg=%b want sel=%b db=%b chg=%b",
                  name, {sel1, sel2, sel3}, db, mode_chg, es, ed, ec);
      end
   endtask

   initial begin
      steps[0]  = '{1'b1, 3'b000,  2, 3'b000, 3'b000, 1'b0, "reset"};
      steps[1]  = '{1'b0, 3'b010,  6, 3'b000, 3'b010, 1'b0, "clean_db"};
      steps[2]  = '{1'b0, 3'b010,  1, 3'b010, 3'b010, 1'b1, "clean_sel"};
      steps[3]  = '{1'b0, 3'b010,  1, 3'b010, 3'b010, 1'b0, "clean_pulse_end"};
      steps[4]  = '{1'b0, 3'b010, 12, 3'b010, 3'b010, 1'b0, "clean_hold"};
      steps[5]  = '{1'b0, 3'b000,  1, 3'b010, 3'b010, 1'b0, "release_start"};
      steps[6]  = '{1'b0, 3'b000, 10, 3'b010, 3'b000, 1'b0, "clean_persist"};
      steps[7]  = '{1'b0, 3'b100,  3, 3'b010, 3'b000, 1'b0, "glitch_high"};
      steps[8]  = '{1'b0, 3'b000, 10, 3'b010, 3'b000, 1'b0, "glitch_reject"};
      steps[9]  = '{1'b1, 3'b000,  1, 3'b000, 3'b000, 1'b0, "reset_2"};
      steps[10] = '{1'b0, 3'b110,  7, 3'b010, 3'b110, 1'b1, "simul_sel"};
      steps[11] = '{1'b0, 3'b110,  5, 3'b010, 3'b110, 1'b0, "simul_hold"};
      steps[12] = '{1'b0, 3'b000, 10, 3'b010, 3'b000, 1'b0, "simul_release"};
      steps[13] = '{1'b0, 3'b100,  7, 3'b001, 3'b100, 1'b1, "repress3"};
      steps[14] = '{1'b0, 3'b000, 10, 3'b001, 3'b000, 1'b0, "repress3_release"};
      steps[15] = '{1'b0, 3'b001,  7, 3'b100, 3'b001, 1'b1, "p1_sel"};
      steps[16] = '{1'b0, 3'b000, 10, 3'b100, 3'b000, 1'b0, "p1_release"};
      steps[17] = '{1'b0, 3'b001,  7, 3'b100, 3'b001, 1'b0, "p1_repress"};
      steps[18] = '{1'b0, 3'b001,  5, 3'b100, 3'b001, 1'b0, "p1_repress_hold"};
      steps[19] = '{1'b0, 3'b000, 10, 3'b100, 3'b000, 1'b0, "p1_repress_release"};
      steps[20] = '{1'b1, 3'b000,  1, 3'b000, 3'b000, 1'b0, "reset_3"};
      steps[21] = '{1'b0, 3'b001,  2, 3'b000, 3'b000, 1'b0, "mid_debounce"};
      steps[22] = '{1'b1, 3'b001,  2, 3'b000, 3'b000, 1'b0, "reset_mid_debounce"};
      steps[23] = '{1'b0, 3'b001,  6, 3'b000, 3'b001, 1'b0, "post_reset_db"};
      steps[24] = '{1'b0, 3'b001,  1, 3'b100, 3'b001, 1'b1, "post_reset_sel"};
      steps[25] = '{1'b0, 3'b001,  3, 3'b100, 3'b001, 1'b0, "post_reset_hold"};
      steps[26] = '{1'b1, 3'b000,  1, 3'b000, 3'b000, 1'b0, "reset_4"};
      steps[27] = '{1'b0, 3'b001,  1, 3'b000, 3'b000, 1'b0, "bounce_a"};
      steps[28] = '{1'b0, 3'b000,  1, 3'b000, 3'b000, 1'b0, "bounce_b"};
      steps[29] = '{1'b0, 3'b001,  1, 3'b000, 3'b000, 1'b0, "bounce_c"};
      steps[30] = '{1'b0, 3'b000,  1, 3'b000, 3'b000, 1'b0, "bounce_d"};
      steps[31] = '{1'b0, 3'b001,  5, 3'b000, 3'b000, 1'b0, "bounce_wait"};
      steps[32] = '{1'b0, 3'b001,  1, 3'b000, 3'b001, 1'b0, "bounce_db"};
      steps[33] = '{1'b0, 3'b001,  1, 3'b100, 3'b001, 1'b1, "bounce_sel"};
      steps[34] = '{1'b0, 3'b001,  5, 3'b100, 3'b001, 1'b0, "bounce_hold"};

      @(negedge CLK);
      #1;
      for (int i = 0; i < 35; i++) begin
         run(steps[i].rst, steps[i].btn, steps[i].cycles);
         chk(steps[i].name, steps[i].exp_sel, steps[i].exp_db, steps[i].exp_chg);
      end

      // Reset landing on the mode_chg pulse must clear outputs without a clock.
      run(1'b0, 3'b010, 7);
      chk("pulse_before_reset", 3'b010, 3'b010, 1'b1);
      RST = 1'b1;
      #1;
      chk("async_reset", 3'b000, 3'b000, 1'b0);
      run(1'b1, 3'b000, 2);
      run(1'b0, 3'b000, 20);
      chk("no_residual_event", 3'b000, 3'b000, 1'b0);

      for (int s = 0; s < 150; s++) begin
         if ($urandom_range(0, 19) == 0)
            run(1'b1, 3'($urandom_range(0, 7)), $urandom_range(1, 2));
         else
            run(1'b0, 3'($urandom_range(0, 7)), $urandom_range(1, 12));
      end
      run(1'b0, 3'b000, 12);

      $display("Simulation finished: %0d checks, %0d errors",
               checks + m_checks, errors + m_errors);
      $finish;
   end

endmodule
